// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the int8 CNN datapath (MAC accumulate and requantise
// stages).
//   DATA_W_DEF : default activation/weight width (signed int8)
//   ACC_W_DEF  : default accumulator / dot-product result width
//   q8_t       : signed DATA_W_DEF-bit activation/weight word
//   acc_t      : signed ACC_W_DEF-bit accumulator word
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 32;

    typedef logic signed [DATA_W_DEF-1:0] q8_t;
    typedef logic signed [ACC_W_DEF-1:0]  acc_t;

endpackage : cnn_pkg

// File: rtl/mac_accum_zp_mul.sv
// -----------------------------------------------------------------------------
// zp_mul
// Stage P of the MAC: registered zero-point subtract and multiply.
//   p = (act - zp) * wgt, with the subtract at DATA_W+1 bits and the product at
//   2*DATA_W+1 bits, so no input combination can overflow.
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   en_i            : stage advance; when low every register holds
//   valid_i, last_i : beat valid / final-beat flag
//   act_i, wgt_i    : signed activation and weight
//   zp_i            : signed activation zero point
//   p_o             : registered signed product
//   valid_o, last_o : registered valid / last flags aligned with p_o
// -----------------------------------------------------------------------------
module zp_mul
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     valid_i,
    input  logic                     last_i,
    input  logic signed [DATA_W-1:0] act_i,
    input  logic signed [DATA_W-1:0] wgt_i,
    input  logic signed [DATA_W-1:0] zp_i,
    output logic signed [2*DATA_W:0] p_o,
    output logic                     valid_o,
    output logic                     last_o
);

    localparam int P_W = 2*DATA_W + 1;

    logic signed [DATA_W:0] diff;
    logic signed [P_W-1:0]  p_d;
    logic signed [P_W-1:0]  p_q;
    logic                   valid_q;
    logic                   last_q;

    // One extra bit so that e.g. -128 - 5 = -133 is representable.
    assign diff = (DATA_W+1)'(act_i) - (DATA_W+1)'(zp_i);
    assign p_d  = P_W'(diff) * P_W'(wgt_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                p_q    <= p_d;
                last_q <= last_i;
            end
        end
    end

    assign p_o     = p_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule : zp_mul

// File: rtl/mac_accum.sv
// -----------------------------------------------------------------------------
// mac_accum
// Streaming int8 multiply-accumulate. Each accepted (act, wgt) beat yields
// (act - act_zp) * wgt in stage P (zp_mul); stage A sums the products and, on
// the beat flagged in_last, loads the output register with the dot product and
// the current output-channel index, then clears the sum and advances the
// channel counter (wrapping after num_ch-1; num_ch of 0 or 1 keeps it at 0).
//
// Build option: define MAC_ACCUM_SAT_EN to saturate every accumulate to the
// ACC_W signed range and report any clamp on out_sat; otherwise additions wrap
// and out_sat is tied to 0.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : input beat handshake
//   in_act, in_wgt        : signed activation / weight
//   in_last               : final beat of the dot product
//   act_zp                : activation zero point (quasi-static)
//   num_ch                : channels per output pixel (quasi-static)
//   out_valid / out_ready : result handshake
//   out_acc, out_ch       : dot-product result and its channel index
//   out_sat               : result was clamped
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer holds valid and its data stable until that edge; ready
// may depend combinationally on the consumer's ready (in_ready on out_ready).
// -----------------------------------------------------------------------------
module mac_accum
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CH_W   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_act,
    input  logic signed [DATA_W-1:0] in_wgt,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] act_zp,
    input  logic [CH_W-1:0]          num_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_acc,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_sat
);

    localparam int P_W = 2*DATA_W + 1;

    logic signed [P_W-1:0]   p;
    logic                    p_valid;
    logic                    p_last;
    logic                    stall;
    logic                    advance;
    logic                    accum;
    logic                    emit;
    logic                    ch_wrap;

    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_q,     acc_d;
    logic [CH_W-1:0]         ch_q,      ch_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [CH_W-1:0]         out_ch_q,  out_ch_d;

    // Only a completing dot product needs the output register, so only a last
    // product can be held up by a full, unaccepted output.
    assign stall    = p_valid && p_last && out_valid_q && !out_ready;
    assign advance  = !stall;
    assign in_ready = advance;
    assign accum    = p_valid && !p_last;
    assign emit     = p_valid && p_last && advance;

    zp_mul #(
        .DATA_W (DATA_W)
    ) u_zp_mul (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (advance),
        .valid_i (in_valid),
        .last_i  (in_last),
        .act_i   (in_act),
        .wgt_i   (in_wgt),
        .zp_i    (act_zp),
        .p_o     (p),
        .valid_o (p_valid),
        .last_o  (p_last)
    );

`ifdef MAC_ACCUM_SAT_EN
    // Sum at a width that cannot overflow, then clamp to the ACC_W range.
    localparam int S_W = ((ACC_W > P_W) ? ACC_W : P_W) + 1;

    logic signed [S_W-1:0] sum_wide;
    logic                  ovf;
    logic                  sat_q,     sat_d;
    logic                  out_sat_q, out_sat_d;

    assign sum_wide = S_W'(acc_q) + S_W'(p);
    // In range iff every bit from ACC_W-1 upwards equals the sign bit.
    assign ovf = !((&sum_wide[S_W-1:ACC_W-1]) || !(|sum_wide[S_W-1:ACC_W-1]));

    always_comb begin
        sum = sum_wide[ACC_W-1:0];
        if (ovf) begin
            sum = sum_wide[S_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // Sticky clamp flag for the dot product in progress; it restarts clear
    // once a result is emitted so the next dot product begins clean.
    always_comb begin
        sat_d     = sat_q;
        out_sat_d = out_sat_q;
        if (accum) begin
            sat_d = sat_q | ovf;
        end
        if (emit) begin
            out_sat_d = sat_q | ovf;
            sat_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q     <= 1'b0;
            out_sat_q <= 1'b0;
        end else begin
            sat_q     <= sat_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign out_sat = out_sat_q;
`else
    // Two's-complement wrap at ACC_W bits.
    assign sum     = acc_q + ACC_W'(p);
    assign out_sat = 1'b0;
`endif

    // Compare at CH_W+1 bits so num_ch = 0 cannot underflow.
    assign ch_wrap = (({1'b0, ch_q} + (CH_W+1)'(1)) >= {1'b0, num_ch});

    always_comb begin
        acc_d       = acc_q;
        ch_d        = ch_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_ch_d    = out_ch_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accum) begin
            acc_d = sum;
        end
        // A drain in the same cycle is overridden here, keeping out_valid high.
        if (emit) begin
            out_valid_d = 1'b1;
            out_acc_d   = sum;
            out_ch_d    = ch_q;
            acc_d       = '0;
            ch_d        = ch_wrap ? '0 : ch_q + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_ch_q    <= '0;
        end else begin
            acc_q       <= acc_d;
            ch_q        <= ch_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_ch    = out_ch_q;

endmodule : mac_accum

// File: tb/tb_mac_accum.sv
module tb_mac_accum;

    localparam int CH_W = 10;
    localparam int RW   = 1 + CH_W + 32;
    localparam int RW16 = 1 + CH_W + 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- main DUT (ACC_W = 32) ----------------
    logic              in_valid, in_ready, in_last, out_valid, out_ready, out_sat;
    logic signed [7:0] in_act, in_wgt, act_zp;
    logic [CH_W-1:0]   num_ch, out_ch;
    logic signed [31:0] out_acc;

    mac_accum #(.DATA_W(8), .ACC_W(32), .CH_W(CH_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last),
        .act_zp(act_zp), .num_ch(num_ch),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_ch(out_ch), .out_sat(out_sat)
    );

    // ---------------- narrow DUT (ACC_W = 16) ----------------
    logic              in_valid_b, in_ready_b, in_last_b, out_valid_b, out_ready_b, out_sat_b;
    logic signed [7:0] in_act_b, in_wgt_b, act_zp_b;
    logic [CH_W-1:0]   num_ch_b, out_ch_b;
    logic signed [15:0] out_acc_b;

    mac_accum #(.DATA_W(8), .ACC_W(16), .CH_W(CH_W)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_act(in_act_b), .in_wgt(in_wgt_b), .in_last(in_last_b),
        .act_zp(act_zp_b), .num_ch(num_ch_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_acc(out_acc_b), .out_ch(out_ch_b), .out_sat(out_sat_b)
    );

    // ---------------- scoreboard ----------------
    logic [RW-1:0]   exp_q[$];
    logic [RW16-1:0] exp16_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic push(input int acc, input int ch, input bit sat);
        logic [RW-1:0] e;
        e = {sat, 10'(ch), 32'(acc)};
        exp_q.push_back(e);
    endtask

    task automatic push16(input int acc, input int ch, input bit sat);
        logic [RW16-1:0] e;
        e = {sat, 10'(ch), 16'(acc)};
        exp16_q.push_back(e);
    endtask

    // Monitor for the main DUT: pops on each output transfer and checks that a
    // stalled output does not move.
    logic [RW-1:0] held;
    bit            held_v = 1'b0;
    always @(negedge clk) begin
        logic [RW-1:0] got, want;
        got = {out_sat, out_ch, out_acc};
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) begin
                n_vec++;
                if (got !== held) begin
                    n_err++;
                    $display("FAIL hold: got acc=%0d ch=%0d expected acc=%0d ch=%0d",
                             out_acc, out_ch, $signed(held[31:0]), held[41:32]);
                end
            end
            held_v = out_valid && !out_ready;
            held   = got;
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: got acc=%0d ch=%0d expected no output",
                             out_acc, out_ch);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL result: got acc=%0d ch=%0d sat=%0d expected acc=%0d ch=%0d sat=%0d",
                                 out_acc, out_ch, out_sat,
                                 $signed(want[31:0]), want[41:32], want[42]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [RW16-1:0] got, want;
        got = {out_sat_b, out_ch_b, out_acc_b};
        if (!rst && out_valid_b && out_ready_b) begin
            n_vec++;
            if (exp16_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out16: got acc=%0d expected no output", out_acc_b);
            end else begin
                want = exp16_q.pop_front();
                if (got !== want) begin
                    n_err++;
                    $display("FAIL result16: got acc=%0d ch=%0d sat=%0d expected acc=%0d ch=%0d sat=%0d",
                             out_acc_b, out_ch_b, out_sat_b,
                             $signed(want[15:0]), want[25:16], want[26]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Presents one beat; returns #1 after the accepting edge. waits = number of
    // cycles in_ready was low before acceptance.
    task automatic send(input int act, input int wgt, input bit last, output int waits);
        bit ok;
        ok       = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_act   = 8'(act);
        in_wgt   = 8'(wgt);
        in_last  = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_b(input int act, input int wgt, input bit last);
        in_valid_b = 1'b1;
        in_act_b   = 8'(act);
        in_wgt_b   = 8'(wgt);
        in_last_b  = last;
        @(negedge clk);
        check("ready16", in_ready_b, 1);
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        in_last_b  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Five single-beat vectors: (act, wgt) and hand-computed products.
    int t3_act[5] = '{10, -50, 127, -128, 0};
    int t3_wgt[5] = '{-3, 4, 127, 127, 99};
    int t3_exp[5] = '{-30, -200, 16129, -16256, 0};
    int t3_ch[5]  = '{0, 1, 2, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        rst = 1'b1;
        in_valid = 1'b0; in_act = '0; in_wgt = '0; in_last = 1'b0;
        act_zp = '0; num_ch = 10'd1; out_ready = 1'b1;
        in_valid_b = 1'b0; in_act_b = '0; in_wgt_b = '0; in_last_b = 1'b0;
        act_zp_b = '0; num_ch_b = 10'd1; out_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_acc", out_acc, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_valid16", out_valid_b, 0);
        @(posedge clk); #1;

        // 4-beat dot product, latency: out_valid high two cycles after last accept
        push(300, 0, 0);
        send(10, 1, 0, w);
        send(20, 2, 0, w);
        send(30, 3, 0, w);
        send(40, 4, 1, w);
        @(negedge clk);
        check("lat_t1", out_valid, 0);
        @(negedge clk);
        check("lat_t2", out_valid, 1);
        idle(3);

        // Zero-point subtract needs 9 bits: (-128-5)*(-128) = 17024
        act_zp = 8'sd5;
        push(17024, 0, 0);
        send(-128, -128, 1, w);
        idle(4);

        // Negative zero point, num_ch = 0 keeps channel at 0
        act_zp = -8'sd3;
        num_ch = 10'd0;
        push(-35, 0, 0);   // (4+3)*(-5)
        push(-2, 0, 0);    // (-1+3)*(-1)
        push(260, 0, 0);   // (127+3)*2
        send(4, -5, 1, w);
        send(-1, -1, 1, w);
        send(127, 2, 1, w);
        idle(4);

        // num_ch = 3, five back-to-back single-beat vectors at full rate
        act_zp = '0;
        num_ch = 10'd3;
        for (int i = 0; i < 5; i++) push(t3_exp[i], t3_ch[i], 0);
        for (int i = 0; i < 5; i++) begin
            send(t3_act[i], t3_wgt[i], 1, w);
            check("full_rate_waits", w, 0);
        end
        idle(4);

        // Backpressure: first result pending, second 3-beat vector stalls at stage A
        out_ready = 1'b0;
        push(6, 2, 0);     // 2*3, channel 2
        push(14, 0, 0);    // 1+4+9, channel wraps to 0
        send(2, 3, 1, w);
        send(1, 1, 0, w);
        check("bp_wait1", w, 0);
        send(2, 2, 0, w);
        check("bp_wait2", w, 0);
        send(3, 3, 1, w);
        check("bp_wait3", w, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_acc", out_acc, 6);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_release", in_ready, 1);
        idle(4);

        // Reset mid-dot-product (channel counter is at 1 here)
        send(5, 5, 0, w);
        send(6, 6, 0, w);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        push(21, 0, 0);
        send(3, 7, 1, w);
        idle(4);

        // ACC_W = 16: 3 * 127*127 = 48387 overflows 16 bits
`ifdef MAC_ACCUM_SAT_EN
        push16(32767, 0, 1);
`else
        push16(-17149, 0, 0);
`endif
        push16(1, 0, 0);   // next dot product starts with a clear flag
        send_b(127, 127, 0);
        send_b(127, 127, 0);
        send_b(127, 127, 1);
        send_b(1, 1, 1);

        // Drain
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && exp16_q.size() == 0) break;
            @(posedge clk);
        end
        idle(2);
        check("drain_main", exp_q.size(), 0);
        check("drain_16", exp16_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mac_accum
